// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module   : branch_predict_unit
// Purpose  : Fetch-stage predictor with a tagged BTB, a gshare PHT and an
//            optional return address stack (enabled by defining RAS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 2,
    parameter int BTB_ENTRIES   = 256,
    parameter int PHT_ENTRIES   = 1024,
    parameter int GHR_WIDTH     = 10,
    parameter int RAS_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  hit,
    output logic                  pred,
    output logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  update_btb,
    input  logic                  update_predictor,
    input  logic                  actually_taken,
    input  logic [DATA_WIDTH-1:0] resolved_pc,
    input  logic [DATA_WIDTH-1:0] resolved_pc_target,
    input  logic [1:0]            resolved_type
);

    localparam int c_BIW = $clog2(BTB_ENTRIES);
    localparam int c_PIW = $clog2(PHT_ENTRIES);
    localparam int c_TW  = DATA_WIDTH - c_BIW - 2;

    localparam logic [1:0] c_TYPE_COND = 2'b00;
    localparam logic [1:0] c_TYPE_CALL = 2'b10;
    localparam logic [1:0] c_TYPE_RET  = 2'b11;

    localparam logic [COUNTER_WIDTH-1:0] c_CTR_MAX  = '1;
    localparam logic [COUNTER_WIDTH-1:0] c_CTR_MIN  = '0;
    localparam logic [COUNTER_WIDTH-1:0] c_CTR_INIT =
        COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);

    logic                     btb_valid_q [BTB_ENTRIES];
    logic [c_TW-1:0]          btb_tag_q   [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]    btb_tgt_q   [BTB_ENTRIES];
    logic [1:0]               btb_type_q  [BTB_ENTRIES];
    logic [COUNTER_WIDTH-1:0] pht_q       [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0]     ghr_q, ghr_d;

    logic [c_PIW-1:0]         w_ghr_ext;
    logic [c_BIW-1:0]         w_lk_idx, w_up_idx;
    logic [c_TW-1:0]          w_lk_tag, w_up_tag;
    logic [c_PIW-1:0]         w_lk_pidx, w_up_pidx;
    logic                     w_lk_hit;
    logic [1:0]               w_lk_type;
    logic [COUNTER_WIDTH-1:0] w_lk_ctr, w_ctr_old, w_ctr_new;
    logic                     w_unused;

    assign w_ghr_ext = c_PIW'(ghr_q);
    assign w_lk_idx  = pc[c_BIW+1:2];
    assign w_lk_tag  = pc[DATA_WIDTH-1:c_BIW+2];
    assign w_lk_pidx = pc[c_PIW+1:2] ^ w_ghr_ext;
    assign w_up_idx  = resolved_pc[c_BIW+1:2];
    assign w_up_tag  = resolved_pc[DATA_WIDTH-1:c_BIW+2];
    assign w_up_pidx = resolved_pc[c_PIW+1:2] ^ w_ghr_ext;
    assign w_unused  = ^{pc[1:0], resolved_pc[1:0]};

    assign w_lk_hit  = btb_valid_q[w_lk_idx] && (btb_tag_q[w_lk_idx] == w_lk_tag);
    assign w_lk_type = btb_type_q[w_lk_idx];
    assign w_lk_ctr  = pht_q[w_lk_pidx];
    assign w_ctr_old = pht_q[w_up_pidx];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (actually_taken) begin
            if (w_ctr_old != c_CTR_MAX) w_ctr_new = w_ctr_old + COUNTER_WIDTH'(1);
        end else begin
            if (w_ctr_old != c_CTR_MIN) w_ctr_new = w_ctr_old - COUNTER_WIDTH'(1);
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (update_predictor) ghr_d = {ghr_q[GHR_WIDTH-2:0], actually_taken};
    end

`ifdef RAS_EN
    localparam int c_RW = $clog2(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [c_RW-1:0]       ras_ptr_q, ras_ptr_d;
    logic [c_RW:0]         ras_cnt_q, ras_cnt_d;
    logic [c_RW-1:0]       w_ras_top_idx;
    logic                  w_ras_push, w_ras_pop, w_ras_nonempty;

    assign w_ras_nonempty = (ras_cnt_q != '0);
    assign w_ras_push     = update_btb && (resolved_type == c_TYPE_CALL);
    assign w_ras_pop      = update_btb && (resolved_type == c_TYPE_RET) && w_ras_nonempty;
    assign w_ras_top_idx  = ras_ptr_q - c_RW'(1);

    // ras_ptr_q is the next free slot; when full it points at the oldest entry
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (w_ras_push) begin
            ras_ptr_d = ras_ptr_q + c_RW'(1);
            if (ras_cnt_q != (c_RW+1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + (c_RW+1)'(1);
        end else if (w_ras_pop) begin
            ras_ptr_d = w_ras_top_idx;
            ras_cnt_d = ras_cnt_q - (c_RW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ras_push) ras_q[ras_ptr_q] <= resolved_pc + DATA_WIDTH'(4);
    end
`endif

    always_comb begin
        hit           = w_lk_hit;
        pred          = 1'b0;
        branch_target = '0;
        if (w_lk_hit) begin
            pred          = (w_lk_type == c_TYPE_COND) ? w_lk_ctr[COUNTER_WIDTH-1] : 1'b1;
            branch_target = btb_tgt_q[w_lk_idx];
`ifdef RAS_EN
            if ((w_lk_type == c_TYPE_RET) && w_ras_nonempty) branch_target = ras_q[w_ras_top_idx];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
        end else if (update_btb) begin
            btb_valid_q[w_up_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observable through a set valid bit
    always_ff @(posedge clk) begin
        if (update_btb) begin
            btb_tag_q[w_up_idx]  <= w_up_tag;
            btb_tgt_q[w_up_idx]  <= resolved_pc_target;
            btb_type_q[w_up_idx] <= resolved_type;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= c_CTR_INIT;
            ghr_q <= '0;
        end else begin
            if (update_predictor) pht_q[w_up_pidx] <= w_ctr_new;
            ghr_q <= ghr_d;
        end
    end

endmodule

`default_nettype wire
